// File: rtl/aes_ctr_keystream_engine.sv
// CTR-mode sequencer in front of an AES-128 core. It holds the counter block and
// the key, starts one encryption per input block, and XORs the returned keystream
// with the block before passing it downstream. Only one block is in flight at a time.
module aes_ctr_keystream_engine #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_iv,
  input  logic [127:0] iv_in,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [4:0]   in_bytes,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         core_start,
  output logic [127:0] core_block,
  output logic [127:0] core_key,
  input  logic [127:0] core_result,
  input  logic         core_done,
  output logic         busy,
  output logic         ctr_wrap,
  output logic [31:0]  block_count
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_e;

  // Low bits that count; upper bits of the counter block never change.
  localparam logic [127:0] LOW_MASK = (CTR_WIDTH >= 128) ? {128{1'b1}}
                                    : ((128'd1 << CTR_WIDTH) - 128'd1);

  state_e       state_q, state_d;
  logic [127:0] ctr_q, key_q, data_q, out_data_q;
  logic [4:0]   bytes_q;
  logic         iv_loaded_q, ctr_wrap_q, core_done_q;
  logic [31:0]  block_count_q;

  logic         done_rise;
  logic [127:0] ctr_inc;
  logic         ctr_at_max;
  logic [4:0]   eff_bytes;
  logic [127:0] keep_mask;

  // A done level held over from the previous block must not complete this one.
  assign done_rise  = core_done && !core_done_q;

  assign ctr_inc    = (ctr_q & ~LOW_MASK) | ((ctr_q + 128'd1) & LOW_MASK);
  assign ctr_at_max = ((ctr_q & LOW_MASK) == LOW_MASK);

  assign eff_bytes  = (bytes_q == 5'd0 || bytes_q > 5'd16) ? 5'd16 : bytes_q;

  // Byte-granular keep mask; byte 0 is the most significant byte.
  always_comb begin
    keep_mask = '0;
    for (int k = 0; k < 16; k++)
      if (k < int'(eff_bytes)) keep_mask[127-8*k -: 8] = 8'hFF;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; load_iv wins over a same-cycle input block.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!load_iv && in_valid && iv_loaded_q) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done_rise) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and control outputs decoded from the registered state.
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE:  begin in_ready = iv_loaded_q; busy = 1'b0; end
      S_START: core_start = 1'b1;
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: IV/key load, input capture, and result/counter update on done edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q         <= '0;
      key_q         <= '0;
      data_q        <= '0;
      bytes_q       <= '0;
      out_data_q    <= '0;
      iv_loaded_q   <= 1'b0;
      ctr_wrap_q    <= 1'b0;
      core_done_q   <= 1'b0;
      block_count_q <= '0;
    end else begin
      core_done_q <= core_done;
      if (state_q == S_IDLE) begin
        if (load_iv) begin
          ctr_q         <= iv_in;
          key_q         <= key_in;
          iv_loaded_q   <= 1'b1;
          ctr_wrap_q    <= 1'b0;
          block_count_q <= '0;
        end else if (in_valid && iv_loaded_q) begin
          data_q  <= in_data;
          bytes_q <= in_bytes;
        end
      end
      if (state_q == S_WAIT && done_rise) begin
        out_data_q    <= (data_q ^ core_result) & keep_mask;
        ctr_q         <= ctr_inc;
        block_count_q <= block_count_q + 32'd1;
        if (ctr_at_max) ctr_wrap_q <= 1'b1;
      end
    end
  end

  assign out_data    = out_data_q;
  assign core_block  = ctr_q;
  assign core_key    = key_q;
  assign ctr_wrap    = ctr_wrap_q;
  assign block_count = block_count_q;

endmodule

// File: tb/tb_aes_ctr_keystream_engine.sv
// Directed bench: behavioural AES core stand-in with SP800-38A keystream blocks.
module tb_aes_ctr_keystream_engine;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV1P = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] KS1  = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] KS2  = 128'h362b7c3c6773516318a077d7fc5073ae;
  localparam logic [127:0] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] CT2  = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] CT1P = 128'h874d6191b60000000000000000000000;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IVW  = 128'h0011223344556677_8899aabb_ffffffff;
  localparam logic [127:0] IVWN = 128'h0011223344556677_8899aabb_00000000;
  localparam logic [127:0] DW   = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [127:0] FAKE = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  localparam int LAT = 5;

  logic clk = 1'b0, rst = 1'b1, load_iv = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] iv_in = '0, key_in = '0, in_data = '0;
  logic [4:0] in_bytes = '0;
  logic in_ready, out_valid, core_start, busy, ctr_wrap;
  logic [127:0] out_data, core_block, core_key;
  logic [127:0] core_result = '0;
  logic core_done = 1'b0;
  logic [31:0] block_count;

  int tests = 0, fails = 0;
  int cnt = 0, start_cnt = 0;
  logic [127:0] held;

  always #5 clk = ~clk;

  aes_ctr_keystream_engine #(.CTR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load_iv(load_iv), .iv_in(iv_in), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bytes(in_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_block(core_block), .core_key(core_key),
    .core_result(core_result), .core_done(core_done), .busy(busy),
    .ctr_wrap(ctr_wrap), .block_count(block_count)
  );

  // Known SP800-38A keystream blocks; anything else gets a cheap stand-in.
  function automatic logic [127:0] ks(input logic [127:0] b, input logic [127:0] k);
    if (k == KEY1 && b == IV1)  return KS1;
    if (k == KEY1 && b == IV1P) return KS2;
    return b ^ k ^ FAKE;
  endfunction

  // Core stand-in: done drops on start, rises LAT cycles later and stays high.
  // Block/key are sampled at completion, so they must be held through the wait.
  always @(posedge clk) begin
    if (core_start) begin
      core_done <= 1'b0;
      cnt       <= LAT;
      start_cnt <= start_cnt + 1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_done   <= 1'b1;
        core_result <= ks(core_block, core_key);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [127:0] iv, input logic [127:0] k);
    @(negedge clk); load_iv = 1'b1; iv_in = iv; key_in = k;
    @(negedge clk); load_iv = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic [4:0] nb);
    @(negedge clk); in_valid = 1'b1; in_data = d; in_bytes = nb;
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk(tag, out_valid, 1'b1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_block_count", block_count, 0);
    chk("rst_ctr_wrap", ctr_wrap, 1'b0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("no_iv_in_ready", in_ready, 1'b0);

    // F.5.1 block 1 and 2 back-to-back
    load(IV1, KEY1);
    chk("load_in_ready", in_ready, 1'b1);
    chk("load_core_block", core_block, IV1);
    chk("load_core_key", core_key, KEY1);
    send(PT1, 5'd16);
    chk("b1_busy", busy, 1'b1);
    chk("b1_in_ready", in_ready, 1'b0);
    wait_out("b1_valid");
    chk("b1_out", out_data, CT1);
    chk("b1_count", block_count, 1);
    chk("b1_starts", start_cnt, 1);
    accept();
    chk("b1_idle", busy, 1'b0);
    chk("b2_core_block", core_block, IV1P);
    send(PT2, 5'd16);
    wait_out("b2_valid");
    chk("b2_out", out_data, CT2);
    chk("b2_count", block_count, 2);
    accept();

    // Partial block plus backpressure, then in_bytes=0 means a full block
    load(IV1, KEY1);
    chk("reload_count", block_count, 0);
    send(PT1, 5'd5);
    wait_out("part_valid");
    chk("part_out", out_data, CT1P);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, held);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    accept();
    send(PT2, 5'd0);
    wait_out("zero_bytes_valid");
    chk("zero_bytes_out", out_data, CT2);
    accept();

    // load_iv beats a same-cycle input block
    @(negedge clk); load_iv = 1'b1; iv_in = IVW; key_in = KEY2; in_valid = 1'b1; in_data = DW; in_bytes = 5'd16;
    @(negedge clk); load_iv = 1'b0; in_valid = 1'b0;
    chk("prio_busy", busy, 1'b0);
    chk("prio_core_block", core_block, IVW);

    // Counter wrap
    send(DW, 5'd16);
    wait_out("wrap_valid");
    chk("wrap_out", out_data, DW ^ IVW ^ KEY2 ^ FAKE);
    chk("wrap_core_block", core_block, IVWN);
    chk("wrap_flag", ctr_wrap, 1'b1);
    accept();
    chk("wrap_sticky", ctr_wrap, 1'b1);
    load(IV1, KEY1);
    chk("wrap_cleared", ctr_wrap, 1'b0);

    // load_iv during S_WAIT is ignored
    send(PT1, 5'd16);
    @(negedge clk);
    load(IVW, KEY2);
    chk("abuse_busy", busy, 1'b1);
    wait_out("abuse_valid");
    chk("abuse_out", out_data, CT1);
    chk("abuse_core_key", core_key, KEY1);
    chk("abuse_core_block", core_block, IV1P);
    accept();

    // Reset during S_WAIT; the late done must not produce output
    send(PT2, 5'd16);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("late_done_out_valid", out_valid, 1'b0);
      chk("late_done_in_ready", in_ready, 1'b0);
    end
    chk("mid_rst_count", block_count, 0);
    chk("mid_rst_done_seen", core_done, 1'b1);
    load(IV1, KEY1);
    chk("post_rst_in_ready", in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
